ysyx_22050019_csr_trap: RTL and testbench

YSYX_22050019_CSR_TRAP -- requirements
Module: ysyx_22050019_csr_trap

---
 rtl/ysyx_22050019_csr_pkg.sv | 44 ++++
 rtl/ysyx_22050019_csr_counter.sv | 37 +++
 rtl/ysyx_22050019_csr_trap.sv | 187 ++++++++++++++++++
 tb/tb_ysyx_22050019_csr_trap.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050019_csr_pkg.sv
// Shared constants for the machine-mode CSR / trap unit: CSR addresses,
// operation encoding, cause codes and bit positions inside mstatus/mie/mip.
package ysyx_22050019_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  // Encodings 6 and 7 are not named and behave like OP_NONE.
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_RW    = 3'd1,
    OP_RS    = 3'd2,
    OP_RC    = 3'd3,
    OP_ECALL = 3'd4,
    OP_MRET  = 3'd5
  } csr_op_e;

  localparam int CAUSE_ECALL_M    = 11;
  localparam int CAUSE_MTIMER_IRQ = 7;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;
  localparam int MIE_MTIE_BIT     = 7;
  localparam int MIP_MTIP_BIT     = 7;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

  // Vectored mode: timer interrupt (cause 7) lands at base + 4*7.
  localparam int VEC_IRQ_OFFSET = 4 * CAUSE_MTIMER_IRQ;

  function automatic logic is_csr_access(input logic [2:0] op);
    return (op == OP_RW) || (op == OP_RS) || (op == OP_RC);
  endfunction

endpackage

// File: rtl/ysyx_22050019_csr_counter.sv
// Free-running XLEN-bit counter with an increment enable and a write port;
// a write in the same cycle takes precedence over the increment.
module ysyx_22050019_csr_counter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] count_o
);

  logic [XLEN-1:0] count_q, count_d;

  // Next count: explicit write wins, otherwise optional +1 (wraps naturally)
  always_comb begin
    count_d = count_q;
    if (we_i) begin
      count_d = wdata_i;
    end else if (inc_i) begin
      count_d = count_q + XLEN'(1);
    end
  end

  // Counter register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ysyx_22050019_csr_trap.sv
// Machine-mode CSR file with ECALL/MRET handling and the machine-timer
// interrupt. Only architecturally needed bits of mstatus/mie are stored.
module ysyx_22050019_csr_trap
  import ysyx_22050019_csr_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [2:0]        op_i,
  input  logic              use_imm_i,
  input  logic [11:0]       csr_addr_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [4:0]        zimm_i,
  input  logic              timer_irq_i,
  output logic [XLEN-1:0]   rdata_o,
  output logic              redirect_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              illegal_o,
  output logic [4*XLEN-1:0] diff_o
);

  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic            mtie_q, mtie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mcycle_val, minstret_val;

  logic [XLEN-1:0] operand, csr_rd, csr_wdata, trap_base, trap_pc;
  logic [XLEN-1:0] mstatus_rd, mie_rd, mip_rd;
  logic            csr_hit, irq_take, ecall_take, mret_take;
  logic            csr_access, csr_we, trap_redirect;
  logic            mcycle_we, minstret_we, minstret_inc;

  assign operand = use_imm_i ? XLEN'(zimm_i) : rs1_data_i;

  // Architectural views of the sparsely stored registers
  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MIE_BIT]  = mstatus_mie_q;
    mstatus_rd[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mie_rd = '0;
    mie_rd[MIE_MTIE_BIT] = mtie_q;
    mip_rd = '0;
    mip_rd[MIP_MTIP_BIT] = timer_irq_i;
  end

  // CSR read mux; unimplemented addresses read as zero
  always_comb begin
    csr_rd  = '0;
    csr_hit = 1'b1;
    case (csr_addr_i)
      CSR_MSTATUS:  csr_rd = mstatus_rd;
      CSR_MIE:      csr_rd = mie_rd;
      CSR_MTVEC:    csr_rd = mtvec_q;
      CSR_MEPC:     csr_rd = mepc_q;
      CSR_MCAUSE:   csr_rd = mcause_q;
      CSR_MIP:      csr_rd = mip_rd;
      CSR_MCYCLE:   csr_rd = mcycle_val;
      CSR_MINSTRET: csr_rd = minstret_val;
      default:      csr_hit = 1'b0;
    endcase
  end

  // Priority: interrupt, then ECALL/MRET, then ordinary CSR access
  assign irq_take   = valid_i & mstatus_mie_q & mtie_q & timer_irq_i;
  assign ecall_take = valid_i & ~irq_take & (op_i == OP_ECALL);
  assign mret_take  = valid_i & ~irq_take & (op_i == OP_MRET);
  assign csr_access = valid_i & ~irq_take & is_csr_access(op_i);

  // Read-modify-write value for RW/RS/RC
  always_comb begin
    case (op_i)
      OP_RS:   csr_wdata = csr_rd | operand;
      OP_RC:   csr_wdata = csr_rd & ~operand;
      default: csr_wdata = operand;
    endcase
  end

  // Set/clear with a zero operand is a pure read and must not write
  assign csr_we = csr_access & csr_hit & ((op_i == OP_RW) | (operand != '0));

  assign trap_base = mtvec_q & ~XLEN'(3);

  // Next-state for trap CSRs plus the redirect request
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mtie_d         = mtie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    trap_redirect  = 1'b0;
    trap_pc        = '0;
    if (irq_take) begin
      mepc_d             = pc_i & ~XLEN'(3);
      mcause_d           = XLEN'(CAUSE_MTIMER_IRQ);
      mcause_d[XLEN-1]   = 1'b1;
      mstatus_mpie_d     = mstatus_mie_q;
      mstatus_mie_d      = 1'b0;
      trap_redirect      = 1'b1;
      trap_pc            = (mtvec_q[1:0] == MTVEC_MODE_VECTORED) ?
                           trap_base + XLEN'(VEC_IRQ_OFFSET) : trap_base;
    end else if (ecall_take) begin
      mepc_d         = pc_i & ~XLEN'(3);
      mcause_d       = XLEN'(CAUSE_ECALL_M);
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      trap_redirect  = 1'b1;
      trap_pc        = trap_base;
    end else if (mret_take) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
      trap_redirect  = 1'b1;
      trap_pc        = mepc_q;
    end else if (csr_we) begin
      case (csr_addr_i)
        CSR_MSTATUS: begin
          mstatus_mie_d  = csr_wdata[MSTATUS_MIE_BIT];
          mstatus_mpie_d = csr_wdata[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:    mtie_d = csr_wdata[MIE_MTIE_BIT];
        CSR_MTVEC:  mtvec_d = (csr_wdata & ~XLEN'(3)) |
                              XLEN'((csr_wdata[1:0] == MTVEC_MODE_VECTORED) ?
                                    MTVEC_MODE_VECTORED : MTVEC_MODE_DIRECT);
        CSR_MEPC:   mepc_d = csr_wdata & ~XLEN'(3);
        CSR_MCAUSE: mcause_d = csr_wdata;
        default: ;
      endcase
    end
  end

  // Trap CSR registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mtie_q         <= 1'b0;
      mtvec_q        <= MTVEC_RST;
      mepc_q         <= '0;
      mcause_q       <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mtie_q         <= mtie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
    end
  end

  assign mcycle_we    = csr_we & (csr_addr_i == CSR_MCYCLE);
  assign minstret_we  = csr_we & (csr_addr_i == CSR_MINSTRET);
  assign minstret_inc = valid_i & ~irq_take;

  ysyx_22050019_csr_counter #(.XLEN(XLEN)) u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (1'b1),
    .we_i    (mcycle_we),
    .wdata_i (csr_wdata),
    .count_o (mcycle_val)
  );

  ysyx_22050019_csr_counter #(.XLEN(XLEN)) u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (minstret_inc),
    .we_i    (minstret_we),
    .wdata_i (csr_wdata),
    .count_o (minstret_val)
  );

  // Control outputs stay quiet while reset is asserted
  assign rdata_o       = csr_rd;
  assign redirect_o    = rst_n & trap_redirect;
  assign redirect_pc_o = (rst_n & trap_redirect) ? trap_pc : '0;
  assign illegal_o     = rst_n & csr_access & ~csr_hit;
  assign diff_o        = {mcause_q, mstatus_rd, mepc_q, mtvec_q};

endmodule

// File: tb/tb_ysyx_22050019_csr_trap.sv
// Randomised bench for the CSR/trap unit: a behavioural model of the CSR
// state is advanced every clock and compared against the DUT on each
// falling edge; directed transactions pin the model with literal values.
module tb_ysyx_22050019_csr_trap;

  localparam logic [63:0] RST_VEC = 64'h0000_0000_2000_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_i;
  logic [63:0]  pc_i;
  logic [2:0]   op_i;
  logic         use_imm_i;
  logic [11:0]  csr_addr_i;
  logic [63:0]  rs1_data_i;
  logic [4:0]   zimm_i;
  logic         timer_irq_i;
  logic [63:0]  rdata_o;
  logic         redirect_o;
  logic [63:0]  redirect_pc_o;
  logic         illegal_o;
  logic [255:0] diff_o;

  int errors = 0;
  int checks = 0;

  ysyx_22050019_csr_trap #(.XLEN(64), .MTVEC_RST(RST_VEC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_i       (valid_i),
    .pc_i          (pc_i),
    .op_i          (op_i),
    .use_imm_i     (use_imm_i),
    .csr_addr_i    (csr_addr_i),
    .rs1_data_i    (rs1_data_i),
    .zimm_i        (zimm_i),
    .timer_irq_i   (timer_irq_i),
    .rdata_o       (rdata_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .illegal_o     (illegal_o),
    .diff_o        (diff_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_mtvec, m_mepc, m_mcause, m_mcycle, m_minstret;
  logic        m_mie, m_mpie, m_mtie;
  logic [63:0] n_mtvec, n_mepc, n_mcause, n_mcycle, n_minstret;
  logic        n_mie, n_mpie, n_mtie;
  bit          n_ready = 0;
  logic [63:0] e_rdata, e_rpc;
  logic        e_redirect, e_illegal;

  function automatic logic [63:0] m_mstatus();
    return 64'h1800 | (64'(m_mie) << 3) | (64'(m_mpie) << 7);
  endfunction

  task automatic model_reset();
    m_mtvec = RST_VEC; m_mepc = 0; m_mcause = 0; m_mcycle = 0; m_minstret = 0;
    m_mie = 0; m_mpie = 0; m_mtie = 0;
    n_ready = 0;
  endtask

  task automatic model_eval();
    logic [63:0] old, opnd, nv, base;
    bit hit, irq, csr;
    hit = 1;
    case (csr_addr_i)
      12'h300: old = m_mstatus();
      12'h304: old = m_mtie ? 64'h80 : 64'h0;
      12'h305: old = m_mtvec;
      12'h341: old = m_mepc;
      12'h342: old = m_mcause;
      12'h344: old = timer_irq_i ? 64'h80 : 64'h0;
      12'hB00: old = m_mcycle;
      12'hB02: old = m_minstret;
      default: begin old = 0; hit = 0; end
    endcase
    irq  = valid_i && m_mie && m_mtie && timer_irq_i;
    csr  = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd3);
    base = m_mtvec & ~64'h3;
    opnd = use_imm_i ? {59'b0, zimm_i} : rs1_data_i;
    e_rdata = old; e_illegal = valid_i && !irq && csr && !hit;
    e_redirect = 0; e_rpc = 0;
    n_mtvec = m_mtvec; n_mepc = m_mepc; n_mcause = m_mcause;
    n_mie = m_mie; n_mpie = m_mpie; n_mtie = m_mtie;
    n_mcycle = m_mcycle + 64'd1;
    n_minstret = m_minstret + ((valid_i && !irq) ? 64'd1 : 64'd0);
    if (irq) begin
      n_mepc = pc_i & ~64'h3; n_mcause = 64'h8000_0000_0000_0007;
      n_mpie = m_mie; n_mie = 0;
      e_redirect = 1; e_rpc = (m_mtvec[1:0] == 2'd1) ? base + 64'd28 : base;
    end else if (valid_i && op_i == 3'd4) begin
      n_mepc = pc_i & ~64'h3; n_mcause = 64'd11;
      n_mpie = m_mie; n_mie = 0;
      e_redirect = 1; e_rpc = base;
    end else if (valid_i && op_i == 3'd5) begin
      n_mie = m_mpie; n_mpie = 1;
      e_redirect = 1; e_rpc = m_mepc;
    end else if (valid_i && csr && hit && (op_i == 3'd1 || opnd != 0)) begin
      if (op_i == 3'd1) nv = opnd;
      else if (op_i == 3'd2) nv = old | opnd;
      else nv = old & ~opnd;
      case (csr_addr_i)
        12'h300: begin n_mie = nv[3]; n_mpie = nv[7]; end
        12'h304: n_mtie = nv[7];
        12'h305: n_mtvec = (nv & ~64'h3) | ((nv[1:0] == 2'd1) ? 64'd1 : 64'd0);
        12'h341: n_mepc = nv & ~64'h3;
        12'h342: n_mcause = nv;
        12'hB00: n_mcycle = nv;
        12'hB02: n_minstret = nv;
        default: ;
      endcase
    end
  endtask

  // Compare DUT against model on every falling edge out of reset
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      model_eval();
      chk("rdata", rdata_o, e_rdata);
      chk("illegal", illegal_o, e_illegal);
      chk("redirect", redirect_o, e_redirect);
      chk("redirect_pc", redirect_pc_o, e_rpc);
      chk("diff", diff_o, {m_mcause, m_mstatus(), m_mepc, m_mtvec});
      n_ready = 1;
    end
  end

  // Advance the model with the clock
  always @(posedge clk) begin
    if (rst_n === 1'b1 && n_ready) begin
      m_mtvec = n_mtvec; m_mepc = n_mepc; m_mcause = n_mcause;
      m_mcycle = n_mcycle; m_minstret = n_minstret;
      m_mie = n_mie; m_mpie = n_mpie; m_mtie = n_mtie;
      n_ready = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input logic [2:0] op, input logic [11:0] a,
                       input logic [63:0] rs1, input bit ui, input logic [4:0] z,
                       input logic [63:0] pc, input bit irq);
    valid_i = v; op_i = op; csr_addr_i = a; rs1_data_i = rs1;
    use_imm_i = ui; zimm_i = z; pc_i = pc; timer_irq_i = irq;
    @(negedge clk); #1;
  endtask

  task automatic fin();
    @(posedge clk); #1;
  endtask

  task automatic random_run(input int n);
    logic [11:0] addrs [10] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                                12'h344, 12'hB00, 12'hB02, 12'h7C0, 12'hF11};
    logic [63:0] rs1;
    for (int i = 0; i < n; i++) begin
      rs1 = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rs1 = 0;
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
            addrs[$urandom_range(0, 9)], rs1, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), {$urandom, $urandom} & ~64'h3,
            $urandom_range(0, 3) == 0);
      fin();
    end
  endtask

  initial begin
    rst_n = 0; valid_i = 0; op_i = 0; use_imm_i = 0; csr_addr_i = 0;
    rs1_data_i = 0; zimm_i = 0; pc_i = 0; timer_irq_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_diff", diff_o, {64'h0, 64'h1800, 64'h0, RST_VEC});
    chk("reset_redirect", redirect_o, 1'b0);
    #2 rst_n = 1;

    // CSRRS mstatus with zero operand: read only
    drive(1, 3'd2, 12'h300, 64'h0, 0, 0, 0, 0);
    chk("rs_zero_rdata", rdata_o, 64'h1800);
    fin(); chk("rs_zero_mstatus", diff_o[191:128], 64'h1800);
    drive(1, 3'd1, 12'h305, 64'h8000_0100, 0, 0, 0, 0); fin();
    chk("mtvec_write", diff_o[63:0], 64'h8000_0100);
    drive(1, 3'd2, 12'h300, 64'h0, 1, 5'd8, 0, 0); fin();
    chk("mie_set", diff_o[191:128], 64'h1808);

    // ECALL then MRET
    drive(1, 3'd4, 12'h0, 64'h0, 0, 0, 64'h8000_0040, 0);
    chk("ecall_redirect", redirect_o, 1'b1);
    chk("ecall_target", redirect_pc_o, 64'h8000_0100);
    fin();
    chk("ecall_mepc", diff_o[127:64], 64'h8000_0040);
    chk("ecall_mcause", diff_o[255:192], 64'd11);
    chk("ecall_mstatus", diff_o[191:128], 64'h1880);
    drive(1, 3'd5, 12'h0, 64'h0, 0, 0, 64'h8000_0100, 0);
    chk("mret_target", redirect_pc_o, 64'h8000_0040);
    fin(); chk("mret_mstatus", diff_o[191:128], 64'h1888);

    // CSRRC clears MIE
    drive(1, 3'd3, 12'h300, 64'h8, 0, 0, 0, 0);
    chk("rc_rdata", rdata_o, 64'h1888);
    fin(); chk("rc_mstatus", diff_o[191:128], 64'h1880);

    // Timer interrupt in vectored mode with a CSRRW in flight
    drive(1, 3'd2, 12'h300, 64'h0, 1, 5'd8, 0, 0); fin();
    drive(1, 3'd1, 12'h305, 64'h8000_0101, 0, 0, 0, 0); fin();
    drive(1, 3'd2, 12'h304, 64'h80, 0, 0, 0, 0); fin();
    drive(1, 3'd1, 12'h341, 64'h1234, 0, 0, 64'h8000_0200, 1);
    chk("irq_target", redirect_pc_o, 64'h8000_011C);
    fin();
    chk("irq_mepc", diff_o[127:64], 64'h8000_0200);
    chk("irq_mcause", diff_o[255:192], 64'h8000_0000_0000_0007);
    chk("irq_mstatus", diff_o[191:128], 64'h1880);

    // mcycle wrap and an illegal address
    drive(1, 3'd1, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0); fin();
    drive(1, 3'd2, 12'hB00, 64'h0, 0, 0, 0, 0);
    chk("mcycle_written", rdata_o, 64'hFFFF_FFFF_FFFF_FFFF); fin();
    drive(1, 3'd2, 12'hB00, 64'h0, 0, 0, 0, 0);
    chk("mcycle_wrap", rdata_o, 64'h0); fin();
    drive(1, 3'd1, 12'h7C0, 64'h55, 0, 0, 0, 0);
    chk("illegal_flag", illegal_o, 1'b1);
    chk("illegal_rdata", rdata_o, 64'h0); fin();

    random_run(300);

    // Asynchronous reset between clock edges
    valid_i = 1; op_i = 3'd4; csr_addr_i = 12'hB00; timer_irq_i = 1;
    #2 rst_n = 0; model_reset();
    #1;
    chk("midrst_diff", diff_o, {64'h0, 64'h1800, 64'h0, RST_VEC});
    chk("midrst_redirect", redirect_o, 1'b0);
    chk("midrst_mcycle", rdata_o, 64'h0);
    op_i = 3'd1; csr_addr_i = 12'h7C0; #1;
    chk("midrst_illegal", illegal_o, 1'b0);
    @(posedge clk); #3;
    valid_i = 0; op_i = 0; timer_irq_i = 0; rst_n = 1;

    random_run(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
